// File: rtl/pll_cfg_pkg.sv
// ----------------------------------------------------------------------------
// pll_cfg_pkg : shared opcodes, frame field positions and state encodings
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pll_cfg_pkg;

   localparam logic [3:0] OP_WRITE  = 4'b0001;
   localparam logic [3:0] OP_BCAST  = 4'b0010;
   localparam logic [3:0] OP_STATUS = 4'b1000;

   localparam int STATUS_LEN  = 4;
   localparam int FLD_OP_HI   = 40;
   localparam int FLD_OP_LO   = 37;
   localparam int FLD_TGT_HI  = 36;
   localparam int FLD_TGT_LO  = 32;
   localparam int FLD_WORD_LO = 0;

   typedef enum logic [1:0] {
      CTRL_IDLE   = 2'd0,
      CTRL_DECODE = 2'd1,
      CTRL_WRITE  = 2'd2
   } ctrl_state_t;

   typedef enum logic [2:0] {
      SH_IDLE     = 3'd0,
      SH_SHIFT_LO = 3'd1,
      SH_SHIFT_HI = 3'd2,
      SH_LE_SETUP = 3'd3,
      SH_LE_PULSE = 3'd4
   } shift_state_t;

endpackage

`default_nettype wire

// File: rtl/pll_serial_shifter.sv
// ----------------------------------------------------------------------------
// pll_serial_shifter : 3-wire SCLK/SDATA/LE word serializer, MSB first
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pll_serial_shifter
   import pll_cfg_pkg::*;
#(
   parameter int NUM_PLL       = 6,
   parameter int PLL_WORD_BITS = 32,
   parameter int SCLK_HALF     = 4,
   parameter int LE_CYCLES     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [PLL_WORD_BITS-1:0] word,
   input  logic [NUM_PLL-1:0]       le_mask,
   output logic                     pll_sclk,
   output logic                     pll_sdata,
   output logic [NUM_PLL-1:0]       pll_le,
   output logic                     done
);

   localparam int CNT_MAX = (SCLK_HALF > LE_CYCLES) ? SCLK_HALF : LE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int BW      = (PLL_WORD_BITS > 1) ? $clog2(PLL_WORD_BITS) : 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);
   localparam logic [CW-1:0] LE_LAST   = CW'(LE_CYCLES - 1);
   localparam logic [BW-1:0] BIT_FIRST = BW'(PLL_WORD_BITS - 1);

   shift_state_t             state, state_nxt;
   logic [CW-1:0]            cnt;
   logic [BW-1:0]            bit_cnt, bit_nxt;
   logic [PLL_WORD_BITS-1:0] sreg, sreg_nxt;
   logic [NUM_PLL-1:0]       mask_r, mask_nxt;
   logic                     half_end;
   logic                     le_end;

   assign half_end = (cnt == HALF_LAST);
   assign le_end   = (cnt == LE_LAST);

   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_cnt;
      sreg_nxt  = sreg;
      mask_nxt  = mask_r;
      done      = 1'b0;
      case (state)
         SH_IDLE: begin
            if (start) begin
               state_nxt = SH_SHIFT_LO;
               bit_nxt   = BIT_FIRST;
               sreg_nxt  = word;
               mask_nxt  = le_mask;
            end
         end
         SH_SHIFT_LO: begin
            if (half_end) state_nxt = SH_SHIFT_HI;
         end
         SH_SHIFT_HI: begin
            if (half_end) begin
               if (bit_cnt == '0) begin
                  state_nxt = SH_LE_SETUP;
               end else begin
                  state_nxt = SH_SHIFT_LO;
                  bit_nxt   = bit_cnt - 1'b1;
                  sreg_nxt  = {sreg[PLL_WORD_BITS-2:0], 1'b0};
               end
            end
         end
         SH_LE_SETUP: begin
            if (half_end) state_nxt = SH_LE_PULSE;
         end
         SH_LE_PULSE: begin
            if (le_end) begin
               state_nxt = SH_IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = SH_IDLE;
      endcase
   end

   // Bus pins are registered from the next-state values so the chips never see decode glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SH_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         sreg      <= '0;
         mask_r    <= '0;
         pll_sclk  <= 1'b0;
         pll_sdata <= 1'b0;
         pll_le    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= (state_nxt != state || state == SH_IDLE) ? '0 : cnt + 1'b1;
         bit_cnt   <= bit_nxt;
         sreg      <= sreg_nxt;
         mask_r    <= mask_nxt;
         pll_sclk  <= (state_nxt == SH_SHIFT_HI);
         pll_sdata <= ((state_nxt == SH_SHIFT_LO) || (state_nxt == SH_SHIFT_HI))
                      && sreg_nxt[PLL_WORD_BITS-1];
         pll_le    <= (state_nxt == SH_LE_PULSE) ? mask_nxt : '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pll_cfg_writer.sv
// ----------------------------------------------------------------------------
// pll_cfg_writer : SPI command frame handshake, decode and PLL word dispatch
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pll_cfg_writer
   import pll_cfg_pkg::*;
#(
   parameter int CMD_BIT_NUM   = 41,
   parameter int NUM_PLL       = 6,
   parameter int PLL_WORD_BITS = 32,
   parameter int SCLK_HALF     = 4,
   parameter int LE_CYCLES     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CMD_BIT_NUM-1:0] data,
   input  logic [6:0]             data_num,
   input  logic                   dready,
   output logic                   ack,
   output logic                   pll_sclk,
   output logic                   pll_sdata,
   output logic [NUM_PLL-1:0]     pll_le,
   output logic                   busy,
   output logic                   cfg_err,
   output logic [7:0]             err_cnt
);

   ctrl_state_t            state, state_nxt;
   logic [CMD_BIT_NUM-1:0] cap_data;
   logic [6:0]             cap_num;
   logic [3:0]             opcode;
   logic [4:0]             target;
   logic                   capture;
   logic                   len_ok;
   logic                   is_status;
   logic                   is_uni;
   logic                   is_bcast;
   logic [NUM_PLL-1:0]     le_mask;
   logic                   start;
   logic                   drop;
   logic                   finish;
   logic                   shift_done;

   assign opcode    = cap_data[FLD_OP_HI:FLD_OP_LO];
   assign target    = cap_data[FLD_TGT_HI:FLD_TGT_LO];
   assign len_ok    = (cap_num == 7'(CMD_BIT_NUM));
   assign is_status = (cap_num == 7'(STATUS_LEN)) && (cap_data[3:0] == OP_STATUS);
   assign is_uni    = len_ok && (opcode == OP_WRITE) && (32'(target) < NUM_PLL);
   assign is_bcast  = len_ok && (opcode == OP_BCAST);
   assign le_mask   = is_bcast ? {NUM_PLL{1'b1}} : (NUM_PLL'(1) << target);

   // A new frame waits for both the ack release and the end of any write.
   assign capture   = (state == CTRL_IDLE) && dready && !ack && !busy;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      drop      = 1'b0;
      finish    = 1'b0;
      case (state)
         CTRL_IDLE: begin
            if (capture) state_nxt = CTRL_DECODE;
         end
         CTRL_DECODE: begin
            if (is_status) begin
               state_nxt = CTRL_IDLE;
               finish    = 1'b1;
            end else if (is_uni || is_bcast) begin
               state_nxt = CTRL_WRITE;
               start     = 1'b1;
            end else begin
               state_nxt = CTRL_IDLE;
               finish    = 1'b1;
               drop      = 1'b1;
            end
         end
         CTRL_WRITE: begin
            if (shift_done) begin
               state_nxt = CTRL_IDLE;
               finish    = 1'b1;
            end
         end
         default: state_nxt = CTRL_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CTRL_IDLE;
         cap_data <= '0;
         cap_num  <= '0;
         ack      <= 1'b0;
         busy     <= 1'b0;
         cfg_err  <= 1'b0;
         err_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         cfg_err <= drop;
         if (capture) begin
            cap_data <= data;
            cap_num  <= data_num;
         end
         if (capture) begin
            ack <= 1'b1;
         end else if (ack && !dready) begin
            ack <= 1'b0;
         end
         if (capture) begin
            busy <= 1'b1;
         end else if (finish) begin
            busy <= 1'b0;
         end
         if (drop && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   pll_serial_shifter #(
      .NUM_PLL       (NUM_PLL),
      .PLL_WORD_BITS (PLL_WORD_BITS),
      .SCLK_HALF     (SCLK_HALF),
      .LE_CYCLES     (LE_CYCLES)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .word      (cap_data[FLD_WORD_LO +: PLL_WORD_BITS]),
      .le_mask   (le_mask),
      .pll_sclk  (pll_sclk),
      .pll_sdata (pll_sdata),
      .pll_le    (pll_le),
      .done      (shift_done)
   );

endmodule

`default_nettype wire

// File: doc/pll_cfg_writer.md
# pll_cfg_writer

Command consumer directly downstream of the board's SPI command slave. Takes each completed command frame (`data`, `data_num`, `dready`), acknowledges it with a four-phase handshake, and decodes it. Valid write frames are forwarded as 32-bit register words over a 3-wire serial bus (shared SCLK/SDATA, one latch-enable per chip) to one or all of the on-board PLL synthesizers. Status-read frames are serviced by the SPI slave itself, so this block acknowledges and discards them.

## Interface
- `CMD_BIT_NUM`, 41: command frame width. Layout `[40:37]` opcode, `[36:32]` target, `[31:0]` register word.
- `NUM_PLL`, 6: number of PLL chips and width of `pll_le`.
- `PLL_WORD_BITS`, 32: serial word length, sent MSB first.
- `SCLK_HALF`, 4: clk cycles per SCLK half-period. Must be ≥1.
- `LE_CYCLES`, 8: width of the latch-enable pulse, in clk cycles. Must be ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `data` in CMD_BIT_NUM: frame from the SPI slave. The last received bit is in bit 0.
- `data_num` in 7: number of valid bits received.
- `dready` in 1: frame available. Held high until `ack` is seen.
- `ack` out 1: frame-accepted handshake.
- `pll_sclk` out 1: serial clock. Idles low.
- `pll_sdata` out 1: serial data.
- `pll_le` out NUM_PLL: per-chip latch enable, active-high.
- `busy` out 1: high from frame capture until the write completes.
- `cfg_err` out 1: one-cycle pulse when a frame is dropped as invalid.
- `err_cnt` out 8: saturating count of `cfg_err` pulses.

## Operation
- All outputs reset to 0 (`ack`, `pll_sclk`, `pll_sdata`, `pll_le`, `busy`, `cfg_err`, `err_cnt`).
- Assertion of `rst` at any time aborts immediately: outputs return to 0 asynchronously and the state returns to IDLE. No partial word is latched.
- **Handshake**
  - In IDLE with `dready`=1 and `ack`=0, the block captures `data` and `data_num` into internal registers and sets `ack`=1 on the next edge.
  - `ack` stays high until `dready`=0 is sampled, then drops on the next edge.
  - The block accepts no new frame while `ack`=1 or `busy`=1.
- **Decode** (the cycle after capture)
  - `data_num`==4 and `data[3:0]`==4'b1000: status read. Discard silently, no error.
  - Otherwise, `data_num`≠CMD_BIT_NUM: drop, pulse `cfg_err`.
  - Opcode 4'b0001 with target < NUM_PLL: unicast write to chip `target`.
  - Opcode 4'b0010: broadcast write. Target is ignored; all `pll_le` bits pulse together.
  - Opcode 4'b0001 with target ≥ NUM_PLL, or any other opcode: drop, pulse `cfg_err`.
- **Write state machine:** IDLE → DECODE → SHIFT_LO → SHIFT_HI (loop PLL_WORD_BITS times) → LE_SETUP → LE_PULSE → IDLE.
  - SHIFT_LO drives `pll_sdata` with the current bit, starting at bit 31, and holds `pll_sclk`=0 for SCLK_HALF cycles.
  - SHIFT_HI holds `pll_sclk`=1 for SCLK_HALF cycles. The chip samples on the SCLK rising edge.
  - LE_SETUP holds `pll_sclk`=0 for SCLK_HALF cycles.
  - LE_PULSE drives the selected `pll_le` bit(s) high for LE_CYCLES cycles.
  - `pll_sdata` returns to 0 in IDLE.
- `err_cnt` saturates at 255 and never wraps.

## Timing
- Capture → `ack` high: 1 cycle. `dready` low → `ack` low: 1 cycle.
- Capture → DECODE: 1 cycle. `cfg_err` pulses in the DECODE cycle+1. A dropped frame returns `busy`=0 in the same cycle.
- `busy` rises the cycle after capture.
- Write duration from DECODE to IDLE is 2·PLL_WORD_BITS·SCLK_HALF + SCLK_HALF + LE_CYCLES cycles. With default parameters this is 256+4+8 = 268 cycles.
- `busy` falls on the cycle `pll_le` falls.
- The `ack` and write paths run concurrently. A write may finish before or after `ack` drops; the next capture waits for both.
- `dready` held high after `ack` falls is not possible (the slave clears `dready` on `ack`). If it occurs anyway, it is treated as a new frame once IDLE.

## Structure
- Package `pll_cfg_pkg`:
  - opcode constants `OP_WRITE`=4'b0001, `OP_BCAST`=4'b0010, `OP_STATUS`=4'b1000;
  - state enum;
  - frame field bit positions.
- Sub-module `pll_serial_shifter`: given `start`, `word`, and `le_mask`, it generates SCLK/SDATA/LE with the timing above and returns `done`.
- The top level owns the handshake, decode, and error counter.

## Test plan
- Frame `{4'b0001, 5'd2, 32'hA5A5_0003}` with `data_num`=41 → `ack` high for the handshake.
  - Required: 32 SCLK rising edges, sampled bits = 0xA5A50003 MSB first.
  - Required: only `pll_le[2]` pulses, for 8 cycles; `busy` high for 269 cycles.
- Broadcast `{4'b0010, 5'd31, 32'h0000_0005}` → all 6 `pll_le` bits pulse simultaneously; `cfg_err`=0.
- `data_num`=4 with `data[3:0]`=4'b1000 → `ack` handshake completes, no SCLK activity, `cfg_err`=0.
- `data_num`=41 with target 5'd7, then an opcode 4'b0111 frame, then `data_num`=40 → three `cfg_err` pulses, `err_cnt`=3, no SCLK activity.
- Assert `rst` after 10 SCLK edges → all outputs are 0 within the same cycle and no `pll_le` pulse occurs. A frame sent after release is written correctly.
- Hold `dready` high and present a second frame right after the first `ack` falls → the second frame is not captured until the first write finishes; both words appear on the bus in order.
